// File: rtl/deserializer.sv
// deserializer: serial-to-parallel stage. Packs a valid-qualified 1-bit
// stream MSB-first into DATA_W-bit words and emits each word with its
// bit count as a one-cycle pulse.
// Optional feature macro: DESERIALIZER_GAP_FLUSH_EN
//   defined   -> a gap (valid low) after a partial frame ends the frame
//                (emit if >= MIN_BITS bits, otherwise pulse short_frame_o)
//   undefined -> gaps pause accumulation; only full words are emitted
module deserializer #(
  parameter int DATA_W   = 16,
  parameter int MOD_W    = $clog2(DATA_W),
  parameter int MIN_BITS = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              short_frame_o
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Count value reached just before the final bit of a full word.
  localparam logic [MOD_W:0] LAST_C = (MOD_W+1)'(DATA_W - 1);
`ifdef DESERIALIZER_GAP_FLUSH_EN
  localparam logic [MOD_W:0] MIN_C  = (MOD_W+1)'(MIN_BITS);
`endif

  // Reject configurations the packing logic does not support.
  if (DATA_W < 4 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
    $error("deserializer: DATA_W must be a power of two >= 4");
  end
  if (MIN_BITS < 1 || MIN_BITS >= DATA_W) begin : g_bad_min_bits
    $error("deserializer: MIN_BITS must be in 1..DATA_W-1");
  end

  state_e              state_q, state_d;
  logic [MOD_W:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;
  logic                short_q, short_d;

  logic [MOD_W-1:0]    pos_s;
  logic [DATA_W-1:0]   sr_ins_s;

  // Shift register with the incoming bit written at the current MSB-first slot.
  always_comb begin
    pos_s    = LAST_C[MOD_W-1:0] - cnt_q[MOD_W-1:0];
    sr_ins_s = sr_q;
    sr_ins_s[pos_s] = ser_data_i;
  end

  // Next-state, packing and output-pulse decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    short_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ser_data_val_i) begin
          sr_d             = '0;
          sr_d[DATA_W-1]   = ser_data_i;
          cnt_d            = {{MOD_W{1'b0}}, 1'b1};
          state_d          = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (ser_data_val_i) begin
          if (cnt_q == LAST_C) begin
            // Final bit of a full word: publish it and restart in IDLE.
            data_d  = sr_ins_s;
            mod_d   = '0;
            val_d   = 1'b1;
            sr_d    = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sr_d  = sr_ins_s;
            cnt_d = cnt_q + {{MOD_W{1'b0}}, 1'b1};
          end
        end else begin
`ifdef DESERIALIZER_GAP_FLUSH_EN
          // Gap ends the frame: emit it if long enough, else flag it.
          if (cnt_q >= MIN_C) begin
            data_d = sr_q;
            mod_d  = cnt_q[MOD_W-1:0];
            val_d  = 1'b1;
          end else begin
            short_d = 1'b1;
          end
          sr_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
`else
          // Gap pauses collection; everything holds until the next bit.
          state_d = ST_COLLECT;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sr_d    = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      short_q <= short_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign short_frame_o    = short_q;

endmodule
